pipeline_idc_buffer: RTL and testbench

- Parametrised successor to the fixed ID-control pipeline register. It decouples IF from ID with a DEPTH-entry instruction queue plus one registered output slot.
- Uses valid/ready handshakes on both sides instead of a bare stall input.
- Presents the instruction, PC and pre-extracted register fields to the decode/control logic. A flushed or reset slot carries a canonical NOP.

---
 rtl/pipeline_idc_buffer.sv | 104 ++++++++++
 tb/tb_pipeline_idc_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_idc_buffer.sv
// IF->ID decoupling buffer: a DEPTH-entry instruction FIFO feeding one registered output slot.
// The output slot presents instruction, PC and pre-sliced register fields to decode.
module pipeline_idc_buffer #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ILEN = 32,
    parameter int unsigned DEPTH = 4,
    parameter logic [ILEN-1:0] NOP_INST = ILEN'(32'h00000013)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ILEN-1:0]              instruction_IF,
    input  logic [XLEN-1:0]              pc_IFR,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ILEN-1:0]              instruction_IDC,
    output logic [XLEN-1:0]              pc_IDC,
    output logic [4:0]                   rd_ID,
    output logic [4:0]                   rs1_IDC,
    output logic [4:0]                   rs2_IDC,
    output logic [$clog2(DEPTH+2)-1:0]   count
);

    localparam int unsigned IdxW   = $clog2(DEPTH);
    localparam int unsigned PtrW   = IdxW + 1;
    localparam int unsigned CountW = $clog2(DEPTH + 2);

    logic [ILEN-1:0]   mem_inst [DEPTH];
    logic [XLEN-1:0]   mem_pc   [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic              out_valid_q;
    logic [ILEN-1:0]   inst_q;
    logic [XLEN-1:0]   pc_q;
    logic [CountW-1:0] count_q;

    logic kill;
    logic q_empty, q_full;
    logic accept, consume, slot_free;
    logic load_q, bypass, push;
    logic [IdxW-1:0] rd_idx, wr_idx;

    always_comb begin
        kill      = reset | flush;
        rd_idx    = rd_ptr_q[IdxW-1:0];
        wr_idx    = wr_ptr_q[IdxW-1:0];
        q_empty   = (wr_ptr_q == rd_ptr_q);
        q_full    = (wr_idx == rd_idx) && (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]);
        accept    = in_valid & ~q_full;
        consume   = out_valid_q & out_ready;
        slot_free = ~out_valid_q | out_ready;
        // Queue head wins over the input so ordering stays strict FIFO.
        load_q    = slot_free & ~q_empty;
        bypass    = slot_free & q_empty & accept;
        push      = accept & ~bypass;
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            inst_q      <= NOP_INST;
            pc_q        <= '0;
            count_q     <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (load_q) begin
                rd_ptr_q    <= rd_ptr_q + PtrW'(1);
                out_valid_q <= 1'b1;
                inst_q      <= mem_inst[rd_idx];
                pc_q        <= mem_pc[rd_idx];
            end else if (bypass) begin
                out_valid_q <= 1'b1;
                inst_q      <= instruction_IF;
                pc_q        <= pc_IFR;
            end else if (consume) begin
                out_valid_q <= 1'b0;
            end
            count_q <= count_q + CountW'(accept) - CountW'(consume);
        end
    end

    // Storage needs no reset; the pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (push && !kill) begin
            mem_inst[wr_idx] <= instruction_IF;
            mem_pc[wr_idx]   <= pc_IFR;
        end
    end

    assign in_ready        = ~q_full;
    assign out_valid       = out_valid_q;
    assign instruction_IDC = inst_q;
    assign pc_IDC          = pc_q;
    assign rd_ID           = inst_q[11:7];
    assign rs1_IDC         = inst_q[19:15];
    assign rs2_IDC         = inst_q[24:20];
    assign count           = count_q;

endmodule

// File: tb/tb_pipeline_idc_buffer.sv
// Bench for pipeline_idc_buffer: directed plan steps plus random traffic against a queue model.
module tb_pipeline_idc_buffer;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instruction_IF = '0;
    logic [63:0] pc_IFR = '0;
    logic        in_ready, out_valid;
    logic [31:0] instruction_IDC;
    logic [63:0] pc_IDC;
    logic [4:0]  rd_ID, rs1_IDC, rs2_IDC;
    logic [2:0]  count;

    pipeline_idc_buffer #(
        .XLEN(64), .ILEN(32), .DEPTH(DEPTH), .NOP_INST(NOP)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction_IF(instruction_IF), .pc_IFR(pc_IFR),
        .out_valid(out_valid), .out_ready(out_ready),
        .instruction_IDC(instruction_IDC), .pc_IDC(pc_IDC),
        .rd_ID(rd_ID), .rs1_IDC(rs1_IDC), .rs2_IDC(rs2_IDC),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } item_t;

    // Everything held by the buffer, oldest first; element 0 is the output slot.
    item_t       held[$];
    logic [31:0] last_inst = NOP;
    logic [63:0] last_pc = '0;
    bit          model_ok = 0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int queue_occ();
        return (held.size() > 0) ? held.size() - 1 : 0;
    endfunction

    task automatic cycle(input logic iv, input logic [31:0] inst, input logic [63:0] pc,
                         input logic ordy, input logic fl, input logic rst);
        item_t it;
        bit    rdy;
        in_valid = iv; instruction_IF = inst; pc_IFR = pc;
        out_ready = ordy; flush = fl; reset = rst;
        #1;
        rdy = queue_occ() < DEPTH;
        if (model_ok) chk("in_ready", in_ready, rdy);
        @(posedge clk);
        if (rst || fl) begin
            held.delete();
            last_inst = NOP;
            last_pc = '0;
            model_ok = 1;
        end else begin
            if (held.size() > 0 && ordy) void'(held.pop_front());
            if (iv && rdy) begin
                it.inst = inst;
                it.pc = pc;
                held.push_back(it);
            end
            if (held.size() > 0) begin
                last_inst = held[0].inst;
                last_pc = held[0].pc;
            end
        end
        #1;
        chk("out_valid", out_valid, held.size() > 0);
        chk("instruction", instruction_IDC, last_inst);
        chk("pc", pc_IDC, last_pc);
        chk("rd", rd_ID, last_inst[11:7]);
        chk("rs1", rs1_IDC, last_inst[19:15]);
        chk("rs2", rs2_IDC, last_inst[24:20]);
        chk("count", count, held.size());
    endtask

    initial begin
        // Reset state
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("rst_inst", instruction_IDC, 32'h00000013);
        chk("rst_count", count, 0);

        // Bypass: one-cycle latency from accept to output
        cycle(1'b1, 32'h00a00513, 64'h80000000, 1'b1, 1'b0, 1'b0);
        chk("byp_valid", out_valid, 1);
        chk("byp_rd", rd_ID, 10);
        chk("byp_rs1", rs1_IDC, 0);
        chk("byp_pc", pc_IDC, 64'h80000000);
        chk("byp_count", count, 1);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Fill with the output held
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, $urandom, 64'(k * 4), 1'b0, 1'b0, 1'b0);
            chk("fill_hold_pc", pc_IDC, 64'h0);
        end
        chk("fill_count", count, 5);
        chk("fill_ready", in_ready, 0);
        // X payload while not ready must be ignored
        cycle(1'b1, 32'bx, 64'bx, 1'b0, 1'b0, 1'b0);

        // Drain in order
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
            if (k < 4) chk("drain_pc", pc_IDC, 64'((k + 1) * 4));
        end
        chk("drain_valid", out_valid, 0);
        chk("drain_pc_hold", pc_IDC, 64'h10);
        chk("drain_count", count, 0);

        // Simultaneous push/pop at constant occupancy
        for (int k = 0; k < 3; k++) cycle(1'b1, $urandom, 64'(32'h100 + k * 4), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, $urandom, 64'(32'h200 + k * 4), 1'b1, 1'b0, 1'b0);
            chk("simul_count", count, 3);
            chk("simul_ready", in_ready, 1);
        end

        // Flush with an offered beat
        cycle(1'b1, $urandom, 64'h300, 1'b0, 1'b0, 1'b0);
        chk("pre_flush_count", count, 4);
        cycle(1'b1, 32'h00b00593, 64'h400, 1'b0, 1'b1, 1'b0);
        chk("flush_valid", out_valid, 0);
        chk("flush_count", count, 0);
        chk("flush_inst", instruction_IDC, 32'h00000013);
        chk("flush_pc", pc_IDC, 0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream, then bypass again
        for (int k = 0; k < 4; k++) cycle(1'b1, $urandom, 64'(32'h500 + k * 4), k[0], 1'b0, 1'b0);
        cycle(1'b1, $urandom, 64'h600, 1'b1, 1'b0, 1'b1);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_count", count, 0);
        chk("rst_mid_inst", instruction_IDC, 32'h00000013);
        chk("rst_mid_pc", pc_IDC, 0);
        cycle(1'b1, 32'h00c00613, 64'h700, 1'b0, 1'b0, 1'b0);
        chk("rst_byp_valid", out_valid, 1);
        chk("rst_byp_pc", pc_IDC, 64'h700);

        // Random traffic with varying consumer pressure
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 50; i++) begin
                logic        iv, ordy, fl, rst;
                logic [31:0] inst;
                iv   = $urandom_range(0, 3) != 0;
                ordy = $urandom_range(0, 7) < b;
                fl   = $urandom_range(0, 40) == 0;
                rst  = $urandom_range(0, 80) == 0;
                inst = (queue_occ() >= DEPTH) ? 32'bx : $urandom;
                cycle(iv, inst, {$urandom, $urandom}, ordy, fl, rst);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
